// File: rtl/error_sum_pkg.sv
// Shared types, default sizes and a sum-slicing helper for the error-sum accumulator.
package error_sum_pkg;

    localparam int OUT_BITS_DEF = 8;
    localparam int SUM_W_DEF    = 32;
    localparam int CNT_W_DEF    = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Extract bit k's counter from the packed sums bus (default geometry).
    function automatic logic [SUM_W_DEF-1:0] sum_slice(
        input logic [OUT_BITS_DEF*SUM_W_DEF-1:0] sums,
        input int unsigned                       k
    );
        logic [SUM_W_DEF-1:0] r_val;
        r_val = sums[k*SUM_W_DEF +: SUM_W_DEF];
        return r_val;
    endfunction

endpackage

// File: rtl/error_bit_counter.sv
// Per-output-bit error counter with synchronous clear.
// ERROR_SUM_SATURATE_EN selects saturation at all-ones; otherwise the counter wraps.
module error_bit_counter #(
    parameter int SUM_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [SUM_W-1:0] cnt
);

    localparam logic [SUM_W-1:0] ONE = {{(SUM_W-1){1'b0}}, 1'b1};

    logic [SUM_W-1:0] r_cnt;

    // Counter holds unless cleared or incremented; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= {SUM_W{1'b0}};
        end else if (clr) begin
            r_cnt <= {SUM_W{1'b0}};
        end else if (inc) begin
`ifdef ERROR_SUM_SATURATE_EN
            if (r_cnt != {SUM_W{1'b1}}) begin
                r_cnt <= r_cnt + ONE;
            end
`else
            r_cnt <= r_cnt + ONE;
`endif
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/error_sum_accumulator.sv
// Per-bit mismatch accumulator fed by the chromosome FSM; sums held until software acks.
// Optional build macro ERROR_SUM_SATURATE_EN makes the per-bit counters saturate.
module error_sum_accumulator
    import error_sum_pkg::*;
#(
    parameter int OUT_BITS = OUT_BITS_DEF,
    parameter int SUM_W    = SUM_W_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                      iClock,
    input  logic                      iReset_n,
    input  logic                      iStart,
    input  logic                      iSampleValid,
    output logic                      oSampleReady,
    input  logic [OUT_BITS-1:0]       iChromOutput,
    input  logic [OUT_BITS-1:0]       iExpectedOutput,
    input  logic [OUT_BITS-1:0]       iValidMask,
    input  logic                      iLastSample,
    input  logic                      iAck,
    output logic                      oDone,
    output logic [OUT_BITS*SUM_W-1:0] oErrorSums,
    output logic [CNT_W-1:0]          oSampleCount,
    output logic [1:0]                oState
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t              r_state;
    state_t              w_next_state;
    logic                w_clr;
    logic                w_accept;
    logic                r_ready;
    logic                r_done;
    logic [OUT_BITS-1:0] r_mis;
    logic                r_mis_vld;
    logic [CNT_W-1:0]    r_count;

    assign w_accept = iSampleValid && (r_state == ST_ACCUM);

    // Next-state decode; iStart only acts in IDLE and iAck only in DONE.
    always_comb begin
        w_next_state = r_state;
        w_clr        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (iStart) begin
                    w_next_state = ST_ACCUM;
                    w_clr        = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (w_accept && iLastSample) begin
                    w_next_state = ST_DRAIN;
                end else begin
                    w_next_state = ST_ACCUM;
                end
            end
            ST_DRAIN: begin
                w_next_state = ST_DONE;
            end
            ST_DONE: begin
                if (iAck) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_DONE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register plus ready/done flags registered from the next state.
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_ready <= (w_next_state == ST_ACCUM);
            r_done  <= (w_next_state == ST_DONE);
        end
    end

    // Stage 1: capture scored mismatches of an accepted sample for one cycle.
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            r_mis     <= {OUT_BITS{1'b0}};
            r_mis_vld <= 1'b0;
        end else if (w_clr) begin
            r_mis     <= {OUT_BITS{1'b0}};
            r_mis_vld <= 1'b0;
        end else if (w_accept) begin
            r_mis     <= (iChromOutput ^ iExpectedOutput) & iValidMask;
            r_mis_vld <= 1'b1;
        end else begin
            r_mis_vld <= 1'b0;
        end
    end

    // Accepted-sample counter; wraps naturally at its width.
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            r_count <= {CNT_W{1'b0}};
        end else if (w_clr) begin
            r_count <= {CNT_W{1'b0}};
        end else if (w_accept) begin
            r_count <= r_count + CNT_ONE;
        end
    end

    // Stage 2: one counter per output bit.
    for (genvar k = 0; k < OUT_BITS; k++) begin : g_bit
        error_bit_counter #(
            .SUM_W (SUM_W)
        ) u_cnt (
            .clk   (iClock),
            .rst_n (iReset_n),
            .clr   (w_clr),
            .inc   (r_mis_vld & r_mis[k]),
            .cnt   (oErrorSums[k*SUM_W +: SUM_W])
        );
    end

    assign oSampleReady = r_ready;
    assign oDone        = r_done;
    assign oSampleCount = r_count;
    assign oState       = r_state;

endmodule
